mem_seq_master: RTL and testbench

//  Initiator for the valid/ready single-port memory protocol: the requester side that drives addr/wr_rd/wr_data/valid and consumes ready/rd_data.
//  On start, writes a deterministic pattern to N consecutive locations, then reads them back and compares.

---
 rtl/mem_seq_master.sv | 148 ++++++++++++++
 tb/tb_mem_seq_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_master.sv
// Write-then-read-back traffic engine for a valid/ready single-port memory.
// Writes seed+k to base+k for k in 0..N-1, reads the range back and counts mismatches.
module mem_seq_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   num_tx_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  wr_rd_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [CW-1:0]         num_reg;
    logic [DATA_WIDTH-1:0] seed_reg;
    logic [CW-1:0]         k_reg;
    logic [CW-1:0]         err_cnt_reg;
    logic [ADDR_WIDTH-1:0] first_err_reg;
    logic                  pass_reg;
    logic                  done_reg;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  last_k;
    logic                  mismatch;

    assign cur_addr = base_reg + k_reg[ADDR_WIDTH-1:0];
    assign cur_data = seed_reg + DATA_WIDTH'(k_reg);
    assign last_k   = (k_reg == num_reg - CW'(1));
    assign mismatch = (rd_data_i != cur_data);

    // Request fields derive only from registered state, so they stay put while stalled.
    always_comb begin
        state_next = state_reg;
        valid_o    = 1'b0;
        wr_rd_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = (num_tx_i == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                valid_o = 1'b1;
                wr_rd_o = 1'b1;
                if (ready_i && last_k) begin
                    state_next = READ;
                end
            end
            READ: begin
                valid_o = 1'b1;
                if (ready_i && last_k) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign addr_o           = valid_o ? cur_addr : '0;
    assign wr_data_o        = (state_reg == WRITE) ? cur_data : '0;
    assign busy_o           = valid_o;
    assign done_o           = done_reg;
    assign pass_o           = pass_reg;
    assign err_cnt_o        = err_cnt_reg;
    assign first_err_addr_o = first_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg      <= '0;
            num_reg       <= '0;
            seed_reg      <= '0;
            k_reg         <= '0;
            err_cnt_reg   <= '0;
            first_err_reg <= '0;
            pass_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        base_reg      <= base_addr_i;
                        num_reg       <= num_tx_i;
                        seed_reg      <= seed_i;
                        k_reg         <= '0;
                        err_cnt_reg   <= '0;
                        first_err_reg <= '0;
                        pass_reg      <= 1'b0;
                    end
                end
                WRITE: begin
                    if (ready_i) begin
                        k_reg <= last_k ? '0 : k_reg + CW'(1);
                    end
                end
                READ: begin
                    if (ready_i) begin
                        k_reg <= k_reg + CW'(1);
                        if (mismatch) begin
                            if (err_cnt_reg != '1) begin
                                err_cnt_reg <= err_cnt_reg + CW'(1);
                            end
                            if (err_cnt_reg == '0) begin
                                first_err_reg <= cur_addr;
                            end
                        end
                    end
                end
                DONE: begin
                    pass_reg <= (err_cnt_reg == '0);
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_seq_master.sv
// Directed bench for mem_seq_master with a behavioural single-port memory and a handshake monitor.
module tb_mem_seq_master;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int TMO = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW:0]   num_tx_i;
    logic [DW-1:0] seed_i;
    logic [AW-1:0] addr_o;
    logic          wr_rd_o;
    logic [DW-1:0] wr_data_o;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] rd_data_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic [AW:0]   err_cnt_o;
    logic [AW-1:0] first_err_addr_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [16];
    logic          toggle = 1'b0;
    logic          flip = 1'b0;
    logic          valid_seen;
    logic [AW-1:0] q_addr [$];
    logic          q_wr   [$];
    logic [DW-1:0] q_data [$];

    logic          stall_reg;
    logic [AW-1:0] h_addr;
    logic          h_wr;
    logic [DW-1:0] h_data;

    mem_seq_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .num_tx_i(num_tx_i), .seed_i(seed_i), .addr_o(addr_o), .wr_rd_o(wr_rd_o),
        .wr_data_o(wr_data_o), .valid_o(valid_o), .ready_i(ready_i), .rd_data_i(rd_data_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
        .first_err_addr_o(first_err_addr_o)
    );

    always #5 clk = ~clk;

    // Memory read path, with an optional bit-0 corruption at address 2.
    assign rd_data_i = mem[addr_o] ^ {{(DW-1){1'b0}}, (flip && addr_o == 4'd2)};

    always @(posedge clk) begin
        #1;
        ready_i = toggle ? ~ready_i : 1'b1;
    end

    // Monitor: logs handshakes, updates the memory, checks stalled requests hold still.
    always @(negedge clk) begin
        if (rst) begin
            stall_reg <= 1'b0;
        end else begin
            if (stall_reg) begin
                checks++;
                assert (valid_o === 1'b1 && addr_o === h_addr && wr_rd_o === h_wr && wr_data_o === h_data)
                else begin
                    errors++;
                    $display("FAIL stall_hold observed=v%0b a%0h w%0b d%0h expected=v1 a%0h w%0b d%0h",
                             valid_o, addr_o, wr_rd_o, wr_data_o, h_addr, h_wr, h_data);
                    $error("stall_hold");
                end
            end
            if (valid_o) begin
                valid_seen <= 1'b1;
                if (ready_i) begin
                    q_addr.push_back(addr_o);
                    q_wr.push_back(wr_rd_o);
                    q_data.push_back(wr_rd_o ? wr_data_o : rd_data_i);
                    if (wr_rd_o) mem[addr_o] <= wr_data_o;
                    stall_reg <= 1'b0;
                    $display("txn %s addr=%0h data=%0h", wr_rd_o ? "WR" : "RD", addr_o,
                             wr_rd_o ? wr_data_o : rd_data_i);
                end else begin
                    stall_reg <= 1'b1;
                    h_addr    <= addr_o;
                    h_wr      <= wr_rd_o;
                    h_data    <= wr_data_o;
                end
            end else begin
                stall_reg <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Start a run and wait for done_o; optionally pulse a stray start mid-run.
    task automatic run(input logic [AW-1:0] base, input logic [AW:0] n, input logic [DW-1:0] seed,
                       input bit inject, output int cyc);
        q_addr.delete(); q_wr.delete(); q_data.delete();
        valid_seen = 1'b0;
        @(negedge clk);
        base_addr_i = base; num_tx_i = n; seed_i = seed; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
        while (done_o !== 1'b1 && cyc < TMO) begin
            if (inject && cyc == 3) begin
                start_i = 1'b1; base_addr_i = 4'd9; num_tx_i = 5'd1; seed_i = 16'h7777;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        check("no_timeout", 32'(cyc < TMO), 32'd1);
    endtask

    task automatic check_txns(input string tag, input logic [AW-1:0] base, input int n,
                              input logic [DW-1:0] seed);
        check({tag, "_count"}, 32'(q_addr.size()), 32'(2 * n));
        if (q_addr.size() == 2 * n) begin
            for (int i = 0; i < 2 * n; i++) begin
                int k;
                logic [AW-1:0] ea;
                logic [DW-1:0] ed;
                k  = i % n;
                ea = base + AW'(k);
                ed = seed + DW'(k);
                check({tag, "_addr"}, 32'(q_addr[i]), 32'(ea));
                check({tag, "_dir"}, 32'(q_wr[i]), 32'(i < n));
                if (i < n) check({tag, "_wdata"}, 32'(q_data[i]), 32'(ed));
            end
        end
    endtask

    task automatic check_result(input string tag, input logic p, input logic [AW:0] ec,
                                input logic [AW-1:0] fa);
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_pass"}, 32'(pass_o), 32'(p));
        check({tag, "_errcnt"}, 32'(err_cnt_o), 32'(ec));
        check({tag, "_firsterr"}, 32'(first_err_addr_o), 32'(fa));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        check({tag, "_pass_hold"}, 32'(pass_o), 32'(p));
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; num_tx_i = '0; seed_i = '0; ready_i = 1'b1;
        valid_seen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_outs", 32'({addr_o, wr_rd_o, wr_data_o, done_o, pass_o, err_cnt_o, first_err_addr_o}), 32'd0);
        rst = 1'b0;

        // 1: basic run, ready always high
        run(4'd0, 5'd4, 16'h00A0, 1'b0, cyc);
        check("t1_latency", 32'(cyc), 32'd9);
        check_txns("t1", 4'd0, 4, 16'h00A0);
        check_result("t1", 1'b1, 5'd0, 4'd0);

        // 2: ready toggling
        toggle = 1'b1;
        run(4'd0, 5'd4, 16'h00A0, 1'b0, cyc);
        toggle = 1'b0;
        check_txns("t2", 4'd0, 4, 16'h00A0);
        check_result("t2", 1'b1, 5'd0, 4'd0);

        // 3: address wrap
        run(4'd14, 5'd4, 16'h1234, 1'b0, cyc);
        check("t3_latency", 32'(cyc), 32'd9);
        check_txns("t3", 4'd14, 4, 16'h1234);
        check_result("t3", 1'b1, 5'd0, 4'd0);

        // 4: corrupted read at address 2
        flip = 1'b1;
        run(4'd0, 5'd4, 16'h00A0, 1'b0, cyc);
        flip = 1'b0;
        check_txns("t4", 4'd0, 4, 16'h00A0);
        check_result("t4", 1'b0, 5'd1, 4'd2);

        // 5a: N=0
        run(4'd5, 5'd0, 16'h0001, 1'b0, cyc);
        check("t5_latency", 32'(cyc), 32'd1);
        check("t5_no_valid", 32'(valid_seen), 32'd0);
        check_result("t5", 1'b1, 5'd0, 4'd0);

        // 5b: start during busy is ignored
        run(4'd0, 5'd4, 16'h0100, 1'b1, cyc);
        check("t5b_latency", 32'(cyc), 32'd9);
        check_txns("t5b", 4'd0, 4, 16'h0100);
        check_result("t5b", 1'b1, 5'd0, 4'd0);

        // 6: reset during read phase, then a clean run
        @(negedge clk);
        base_addr_i = 4'd0; num_tx_i = 5'd4; seed_i = 16'h0055; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
        while (!(valid_o === 1'b1 && wr_rd_o === 1'b0) && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t6_reach_read", 32'(cyc < TMO), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_valid", 32'(valid_o), 32'd0);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_outs", 32'({addr_o, wr_rd_o, wr_data_o, done_o, pass_o, err_cnt_o, first_err_addr_o}), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_no_done", 32'(done_o), 32'd0);
        run(4'd3, 5'd2, 16'h0005, 1'b0, cyc);
        check("t6_latency", 32'(cyc), 32'd5);
        check_txns("t6", 4'd3, 2, 16'h0005);
        check_result("t6", 1'b1, 5'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
